sid_regs: RTL and testbench

CPU-facing register file for the 8580 SID core: decodes bus writes at offsets 0x00–0x18 into the parameter buses that drive the three `sid_voice` instances and the filter. It also serves reads of the readable registers 0x19–0x1C: POTX, POTY, OSC3 and ENV3. It sits between the C64 bus glue and the voice/filter datapath and is the writer end of the voice parameter interface.

---
 rtl/sid_pkg.sv | 42 ++++
 rtl/sid_bus_latch.sv | 39 +++
 rtl/sid_regs.sv | 136 +++++++++++++
 tb/tb_sid_regs.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the SID register slice.
// Holds the register offset map, the per-voice stride, a small address helper
// and the decoded bus-access struct used by sid_regs.
package sid_pkg;

  localparam int SID_NUM_VOICES   = 3;
  localparam int SID_VOICE_STRIDE = 7;

  // Per-voice offsets, relative to the voice base (7 * voice)
  localparam logic [4:0] SID_V_FREQ_LO = 5'h00;
  localparam logic [4:0] SID_V_FREQ_HI = 5'h01;
  localparam logic [4:0] SID_V_PW_LO   = 5'h02;
  localparam logic [4:0] SID_V_PW_HI   = 5'h03;
  localparam logic [4:0] SID_V_CONTROL = 5'h04;
  localparam logic [4:0] SID_V_ATT_DEC = 5'h05;
  localparam logic [4:0] SID_V_SUS_REL = 5'h06;

  // Filter / global registers
  localparam logic [4:0] SID_FC_LO     = 5'h15;
  localparam logic [4:0] SID_FC_HI     = 5'h16;
  localparam logic [4:0] SID_RES_FILT  = 5'h17;
  localparam logic [4:0] SID_MODE_VOL  = 5'h18;

  // Readable registers
  localparam logic [4:0] SID_POTX      = 5'h19;
  localparam logic [4:0] SID_POTY      = 5'h1A;
  localparam logic [4:0] SID_OSC3      = 5'h1B;
  localparam logic [4:0] SID_ENV3      = 5'h1C;

  // One decoded CPU access for the current cycle
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [4:0] addr;
    logic [7:0] data;
  } sid_bus_t;

  function automatic logic [4:0] voice_reg(input int v, input logic [4:0] off);
    return 5'(v * SID_VOICE_STRIDE) + off;
  endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// Floating-bus latch with fade-out.
// The latch remembers the last value driven on the data bus and fades to 0x00
// after DECAY_CYCLES ce_1m ticks without a further update.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   ce_1m             - 1 MHz enable, paces the decay counter only
//   upd, upd_data     - load the latch (and restart decay) with upd_data
//   latch             - current latch value
module sid_bus_latch #(
  parameter int DECAY_CYCLES = 200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce_1m,
  input  logic       upd,
  input  logic [7:0] upd_data,
  output logic [7:0] latch
);

  localparam logic [19:0] RELOAD = 20'(DECAY_CYCLES);

  logic [19:0] cnt;

  // An update in the same cycle as the final tick takes priority, so the
  // latch is reloaded rather than cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch <= 8'h00;
      cnt   <= '0;
    end else if (upd) begin
      latch <= upd_data;
      cnt   <= RELOAD;
    end else if (ce_1m && cnt != '0) begin
      cnt <= cnt - 20'd1;
      if (cnt == 20'd1) latch <= 8'h00;
    end
  end

endmodule

// File: rtl/sid_regs.sv
// CPU-facing SID register file.
// Decodes writes at 0x00-0x18 into voice/filter parameter buses and serves
// reads of POTX/POTY/OSC3/ENV3 (0x19-0x1C). Other reads return the
// floating-bus latch when SID_BUS_DECAY_EN is defined, else 0x00.
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   ce_1m                        - 1 MHz enable (bus-latch decay only)
//   cs, we, addr, data_in        - one-cycle access strobe, direction, offset, write data
//   data_out                     - registered read data, held until next read
//   freq[48], pw[36]             - per-voice params, voice n at [16n+:16] / [12n+:12]
//   control, att_dec, sus_rel    - per-voice params, voice n at [8n+:8]
//   fc, res_filt, mode_vol       - filter params
//   potx, poty, osc3, env3       - readback sources
// Build option: SID_BUS_DECAY_EN enables the fading bus latch (sid_bus_latch).
module sid_regs
  import sid_pkg::*;
#(
  parameter int DECAY_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [47:0] freq,
  output logic [35:0] pw,
  output logic [23:0] control,
  output logic [23:0] att_dec,
  output logic [23:0] sus_rel,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  input  logic [7:0]  potx,
  input  logic [7:0]  poty,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3
);

  sid_bus_t acc;
  assign acc = '{wr: cs & we, rd: cs & ~we, addr: addr, data: data_in};

  logic [SID_NUM_VOICES-1:0][15:0] freq_q;
  logic [SID_NUM_VOICES-1:0][11:0] pw_q;
  logic [SID_NUM_VOICES-1:0][7:0]  ctrl_q, ad_q, sr_q;
  logic [10:0] fc_q;
  logic [7:0]  rf_q, mv_q;

  // Every byte is written independently; no low/high staging.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq_q <= '0;
      pw_q   <= '0;
      ctrl_q <= '0;
      ad_q   <= '0;
      sr_q   <= '0;
      fc_q   <= '0;
      rf_q   <= '0;
      mv_q   <= '0;
    end else if (acc.wr) begin
      for (int v = 0; v < SID_NUM_VOICES; v++) begin
        if (acc.addr == voice_reg(v, SID_V_FREQ_LO)) freq_q[v][7:0]  <= acc.data;
        if (acc.addr == voice_reg(v, SID_V_FREQ_HI)) freq_q[v][15:8] <= acc.data;
        if (acc.addr == voice_reg(v, SID_V_PW_LO))   pw_q[v][7:0]    <= acc.data;
        if (acc.addr == voice_reg(v, SID_V_PW_HI))   pw_q[v][11:8]   <= acc.data[3:0];
        if (acc.addr == voice_reg(v, SID_V_CONTROL)) ctrl_q[v]       <= acc.data;
        if (acc.addr == voice_reg(v, SID_V_ATT_DEC)) ad_q[v]         <= acc.data;
        if (acc.addr == voice_reg(v, SID_V_SUS_REL)) sr_q[v]         <= acc.data;
      end
      case (acc.addr)
        SID_FC_LO:    fc_q[2:0]  <= acc.data[2:0];
        SID_FC_HI:    fc_q[10:3] <= acc.data;
        SID_RES_FILT: rf_q       <= acc.data;
        SID_MODE_VOL: mv_q       <= acc.data;
        default: ;
      endcase
    end
  end

  assign freq     = freq_q;
  assign pw       = pw_q;
  assign control  = ctrl_q;
  assign att_dec  = ad_q;
  assign sus_rel  = sr_q;
  assign fc       = fc_q;
  assign res_filt = rf_q;
  assign mode_vol = mv_q;

  // Readback mux
  logic [7:0] rd_val;
  logic       readable;
  always_comb begin
    rd_val   = 8'h00;
    readable = 1'b0;
    case (acc.addr)
      SID_POTX: begin rd_val = potx; readable = 1'b1; end
      SID_POTY: begin rd_val = poty; readable = 1'b1; end
      SID_OSC3: begin rd_val = osc3; readable = 1'b1; end
      SID_ENV3: begin rd_val = env3; readable = 1'b1; end
      default: ;
    endcase
  end

  logic [7:0] latch_val;

`ifdef SID_BUS_DECAY_EN
  // Latch follows every written byte and every value returned from a
  // readable register; reads of write-only addresses leave it alone.
  logic       latch_upd;
  logic [7:0] latch_data;
  assign latch_upd  = acc.wr | (acc.rd & readable);
  assign latch_data = acc.wr ? acc.data : rd_val;

  sid_bus_latch #(.DECAY_CYCLES(DECAY_CYCLES)) u_latch (
    .clock    (clock),
    .reset    (reset),
    .ce_1m    (ce_1m),
    .upd      (latch_upd),
    .upd_data (latch_data),
    .latch    (latch_val)
  );
`else
  assign latch_val = 8'h00;
  logic unused_decay;
  assign unused_decay = ^{ce_1m, 20'(DECAY_CYCLES)};
`endif

  // Latch value returned is the one before this edge's update.
  always_ff @(posedge clock) begin
    if (reset)       data_out <= 8'h00;
    else if (acc.rd) data_out <= readable ? rd_val : latch_val;
  end

endmodule

// File: tb/tb_sid_regs.sv
module tb_sid_regs;

  localparam int DECAY = 4;

  logic        clock = 1'b0;
  logic        reset, ce_1m, cs, we;
  logic [4:0]  addr;
  logic [7:0]  data_in, data_out;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] control, att_dec, sus_rel;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [7:0]  potx, poty, osc3, env3;

  sid_regs #(.DECAY_CYCLES(DECAY)) dut (
    .clock(clock), .reset(reset), .ce_1m(ce_1m), .cs(cs), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .freq(freq), .pw(pw), .control(control), .att_dec(att_dec),
    .sus_rel(sus_rel), .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
    .potx(potx), .poty(poty), .osc3(osc3), .env3(env3)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: a byte-per-offset register image plus a bus latch
  // described as "value, and ticks elapsed since it was last refreshed".
  logic [7:0] regs [32];
  logic [7:0] m_lat;
  int         m_since;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [47:0] e_freq;
    logic [35:0] e_pw;
    logic [23:0] e_ctl, e_ad, e_sr;
    for (int v = 0; v < 3; v++) begin
      e_freq[16*v +: 16] = {regs[7*v+1], regs[7*v]};
      e_pw[12*v +: 12]   = {regs[7*v+3][3:0], regs[7*v+2]};
      e_ctl[8*v +: 8]    = regs[7*v+4];
      e_ad[8*v +: 8]     = regs[7*v+5];
      e_sr[8*v +: 8]     = regs[7*v+6];
    end
    chk("freq", 48'(freq), e_freq);
    chk("pw", 48'(pw), 48'(e_pw));
    chk("control", 48'(control), 48'(e_ctl));
    chk("att_dec", 48'(att_dec), 48'(e_ad));
    chk("sus_rel", 48'(sus_rel), 48'(e_sr));
    chk("fc", 48'(fc), 48'({regs[22], regs[21][2:0]}));
    chk("res_filt", 48'(res_filt), 48'(regs[23]));
    chk("mode_vol", 48'(mode_vol), 48'(regs[24]));
    chk("data_out", 48'(data_out), 48'(m_dout));
  endtask

  function automatic logic [7:0] src_val(input int a);
    case (a)
      25: return potx;
      26: return poty;
      27: return osc3;
      default: return env3;
    endcase
  endfunction

  task automatic model_tick(input logic ce);
    if (ce && m_since < DECAY) begin
      m_since++;
      if (m_since == DECAY) m_lat = 8'h00;
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic w,
                            input int a, input logic [7:0] d, input logic ce);
    logic [7:0] v;
    if (r) begin
      for (int i = 0; i < 32; i++) regs[i] = 8'h00;
      m_dout = 8'h00; m_lat = 8'h00; m_since = DECAY;
    end else if (c && w) begin
      regs[a] = d;
      m_lat = d; m_since = 0;
    end else if (c) begin
      if (a >= 25 && a <= 28) begin
        v = src_val(a);
        m_dout = v; m_lat = v; m_since = 0;
      end else begin
`ifdef SID_BUS_DECAY_EN
        m_dout = m_lat;
`else
        m_dout = 8'h00;
`endif
        model_tick(ce);
      end
    end else begin
      model_tick(ce);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w,
                      input int a, input logic [7:0] d, input logic ce);
    reset = r; cs = c; we = w; addr = 5'(a); data_in = d; ce_1m = ce;
    @(posedge clock);
    model_edge(r, c, w, a, d, ce);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic ce);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, ce);
  endtask

  initial begin
    potx = 8'h11; poty = 8'h22; osc3 = 8'h33; env3 = 8'h44;
    for (int i = 0; i < 32; i++) regs[i] = 8'hxx;
    m_dout = 8'hxx; m_lat = 8'h00; m_since = DECAY;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    idle(1, 1'b0);

    // Frequency pairs and pw high nibble masking
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h34, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h01, 8'h12, 1'b0);
    chk("freq0_1234", 48'(freq[15:0]), 48'h1234);
    step(1'b0, 1'b1, 1'b1, 8'h0A, 8'hFF, 1'b0);
    chk("pw1_hi_nibble", 48'(pw[23:20]), 48'hF);

    // Filter cutoff split
    step(1'b0, 1'b1, 1'b1, 8'h15, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h16, 8'hAB, 1'b0);
    chk("fc_55f", 48'(fc), 48'h55F);

    // Readback: ENV3 sampled at the read edge and held afterwards
    env3 = 8'h80;
    step(1'b0, 1'b1, 1'b0, 8'h1C, 8'h00, 1'b0);
    chk("env3_read", 48'(data_out), 48'h80);
    env3 = 8'h3C;
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h18, 8'h9E, 1'b0);
    chk("env3_held", 48'(data_out), 48'h80);

    // Floating-bus latch
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h5A, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
`ifdef SID_BUS_DECAY_EN
    chk("latch_5a", 48'(data_out), 48'h5A);
    idle(DECAY, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
    chk("latch_decayed", 48'(data_out), 48'h00);
    step(1'b0, 1'b1, 1'b1, 8'h1F, 8'hC3, 1'b1);
    idle(DECAY - 2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h1E, 8'h6D, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
    chk("latch_rewrite_wins", 48'(data_out), 48'h6D);
`else
    chk("no_latch", 48'(data_out), 48'h00);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      potx = 8'($urandom); poty = 8'($urandom);
      osc3 = 8'($urandom); env3 = 8'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)),
           8'($urandom), ($urandom_range(0, 2) == 0));
    end

    // Program everything, then reset with a colliding write
    for (int a = 0; a <= 24; a++) step(1'b0, 1'b1, 1'b1, a, 8'($urandom_range(1, 255)), 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h19, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0);
    chk("rst_freq", 48'(freq), 48'h0);
    chk("rst_pw", 48'(pw), 48'h0);
    chk("rst_ctrl", 48'({control, att_dec}), 48'h0);
    chk("rst_sr", 48'(sus_rel), 48'h0);
    chk("rst_filt", 48'({fc, res_filt, mode_vol}), 48'h0);
    chk("rst_dout", 48'(data_out), 48'h0);
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    chk("rst_latch", 48'(data_out), 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
